// File: rtl/spi_reg_bank.sv
// SPI-fed 8x8 register bank driving a 4-digit BCD display, with an optional
// MISO readback path enabled by defining SPI_REG_BANK_READBACK_EN.
module spi_reg_bank #(
  parameter int          SYNC_STAGES  = 2,
  parameter logic [15:0] RESET_DIGITS = 16'h4300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       spi_cs_n,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [1:0] colon,
  output logic       busy
);

`ifdef SPI_REG_BANK_READBACK_EN
  typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;
`else
  typedef enum logic [1:0] {IDLE, CMD, WR} state_t;
`endif

  logic [SYNC_STAGES-1:0] rx_sync, cs_sync, fill;
  logic                   rx_q, cs_q, cs_armed;
  logic                   byte_evt, cs_fall, cs_rise;

  // fill marks when the synchronizers hold real samples rather than reset levels;
  // cs_armed blocks the phantom cs_fall seen when cs is already low at reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync  <= '0;
      cs_sync  <= '1;
      rx_q     <= 1'b0;
      cs_q     <= 1'b1;
      fill     <= '0;
      cs_armed <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[SYNC_STAGES-2:0], rx_done};
      cs_sync <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      rx_q    <= rx_sync[SYNC_STAGES-1];
      cs_q    <= cs_sync[SYNC_STAGES-1];
      fill    <= {fill[SYNC_STAGES-2:0], 1'b1};
      if (fill[SYNC_STAGES-1] && cs_sync[SYNC_STAGES-1]) cs_armed <= 1'b1;
    end
  end

  assign byte_evt = rx_sync[SYNC_STAGES-1] & ~rx_q;
  assign cs_fall  = ~cs_sync[SYNC_STAGES-1] & cs_q;
  assign cs_rise  = cs_sync[SYNC_STAGES-1] & ~cs_q;

  state_t          state, state_nx;
  logic [2:0]      addr, addr_nx;
  logic            drop, drop_nx, wr_en;
  logic [7:0][7:0] regs;
`ifdef SPI_REG_BANK_READBACK_EN
  logic            rd_en;
  logic [2:0]      rd_addr;
`endif

  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    drop_nx  = drop;
    wr_en    = 1'b0;
`ifdef SPI_REG_BANK_READBACK_EN
    rd_en    = 1'b0;
    rd_addr  = addr;
`endif
    case (state)
      IDLE: if (cs_fall && cs_armed) state_nx = CMD;
      CMD: if (byte_evt) begin
        addr_nx = rx_data[2:0];
`ifdef SPI_REG_BANK_READBACK_EN
        if (rx_data[7]) begin
          // First readback byte is loaded on the command itself.
          state_nx = RD;
          rd_en    = 1'b1;
          rd_addr  = rx_data[2:0];
          addr_nx  = rx_data[2:0] + 3'd1;
        end else begin
          state_nx = WR;
        end
`else
        state_nx = WR;
        drop_nx  = rx_data[7];
`endif
      end
      WR: if (byte_evt) begin
        wr_en   = ~drop;
        addr_nx = addr + 3'd1;
      end
`ifdef SPI_REG_BANK_READBACK_EN
      RD: if (byte_evt) begin
        rd_en   = 1'b1;
        addr_nx = addr + 3'd1;
      end
`endif
      default: state_nx = IDLE;
    endcase
    // Any byte in the same clk has already been acted on above.
    if (cs_rise) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      addr    <= 3'd0;
      drop    <= 1'b0;
      regs    <= '0;
      regs[0] <= RESET_DIGITS[7:0];
      regs[1] <= RESET_DIGITS[15:8];
      regs[2] <= 8'h03;
    end else begin
      state <= state_nx;
      addr  <= addr_nx;
      drop  <= drop_nx;
      if (wr_en) regs[addr] <= rx_data;
    end
  end

`ifdef SPI_REG_BANK_READBACK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= rd_en;
      if (rd_en) tx_data <= regs[rd_addr];
    end
  end
`else
  logic unused;
  assign unused   = ^{regs[7:3], regs[2][7:2]};
  assign tx_data  = 8'h00;
  assign tx_valid = 1'b0;
`endif

  assign digit0 = regs[0][3:0];
  assign digit1 = regs[0][7:4];
  assign digit2 = regs[1][3:0];
  assign digit3 = regs[1][7:4];
  assign colon  = regs[2][1:0];
  assign busy   = (state != IDLE);

endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth for rx_done and spi_cs_n. Legal values are 2..3.
REQ-003 Parameter RESET_DIGITS, default 16'h4300: reset value of {reg1, reg0}.
REQ-004 Port clk, input, 1: system clock, WF_CLK domain.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port rx_data, input, 8: byte from the SPI slave. It is stable from the rising edge of rx_done until the next byte.
REQ-007 Port rx_done, input, 1: byte-received strobe from the SPI clock domain. It is asynchronous to clk.
REQ-008 Port spi_cs_n, input, 1: SPI chip select, active low. It is asynchronous to clk.
REQ-009 Port tx_data, output, 8: next byte for the SPI slave to shift out on MISO.
REQ-010 Port tx_valid, output, 1: one-clk pulse meaning tx_data has been updated.
REQ-011 Port digit0..digit3, output, 4 each: BCD digits for the 7-segment driver. digit0 is the least significant digit.
REQ-012 Port colon, output, 2: colon/decimal-point select. 00 = colon, 01 = decimal point, 11 = none.
REQ-013 Port busy, output, 1: high while a transaction is active, i.e. state is not IDLE.

Function
REQ-014 The block SHALL pass rx_done and spi_cs_n through SYNC_STAGES flops each, then apply rising-edge detection to produce byte_evt and falling/rising edge detection to produce cs_fall and cs_rise.
REQ-015 The register file SHALL be 8 x 8 bits (reg0..reg7).
  - digit0 = reg0[3:0], digit1 = reg0[7:4]
  - digit2 = reg1[3:0], digit3 = reg1[7:4]
  - colon = reg2[1:0]
  - All outputs are driven combinationally from the registers.
REQ-016 The state machine SHALL have the states IDLE, CMD, WR and RD.
REQ-017 Transitions:
  - IDLE -> CMD on cs_fall.
  - CMD -> WR on byte_evt with rx_data[7] = 0; addr <= rx_data[2:0].
  - CMD -> RD on byte_evt with rx_data[7] = 1; addr <= rx_data[2:0].
  - rx_data[6:3] of the command byte is ignored.
REQ-018 In WR, each byte_evt SHALL write reg[addr] <= rx_data and then addr <= addr + 1.
REQ-019 On entering RD, and on each byte_evt while in RD, the block SHALL:
  - load tx_data <= reg[addr];
  - set addr <= addr + 1;
  - pulse tx_valid for exactly one clk.
REQ-020 addr SHALL be 3 bits and wrap from 7 to 0 with no error indication.
REQ-021 A cs_rise in any state SHALL force IDLE on the next clk; addr is retained and tx_data is held.
REQ-022 If byte_evt and cs_rise occur in the same clk, the byte SHALL be processed first and the state SHALL be IDLE afterwards.
REQ-023 A byte_evt while in IDLE SHALL be ignored, with no register or state change.
REQ-024 Latency: a rising edge on rx_done SHALL update the register (or tx_data) no later than SYNC_STAGES + 2 clk later.
REQ-025 Bytes SHALL be no closer together than SYNC_STAGES + 3 clk. Closer spacing is out of specification and its behaviour is undefined.

Reset
REQ-026 On reset assertion, without waiting for clk, the block SHALL set:
  - state = IDLE, addr = 0;
  - {reg1, reg0} = RESET_DIGITS, reg2 = 8'h03, reg3..reg7 = 0;
  - tx_data = 8'h00, tx_valid = 0, busy = 0;
  - all synchronizer and edge-detect flops = idle levels (rx_done low, spi_cs_n high).
REQ-027 Reset asserted mid-transaction SHALL discard the transaction. After release the block SHALL wait for a fresh cs_fall before accepting bytes.

Configuration
REQ-028 The macro SPI_REG_BANK_READBACK_EN selects whether read transactions are supported.
REQ-029 With SPI_REG_BANK_READBACK_EN defined, RD behaves as specified in REQ-019.
REQ-030 Without SPI_REG_BANK_READBACK_EN:
  - the RD state and tx path are compiled out;
  - tx_data is tied to 8'h00 and tx_valid is tied to 0;
  - a command byte with bit7 = 1 moves to WR instead of RD, but every data byte in that transaction is dropped with no write.

Verification
REQ-031 Reset, then hold idle: digit3..digit0 = 4, 3, 0, 0; colon = 11; busy = 0; tx_valid never pulses.
REQ-032 Write with wrap: cs low, bytes 0x07, 0xAA, 0x21, cs high. Result: reg7 = 0xAA, reg0 = 0x21, digit1 = 2, digit0 = 1; busy returns low within SYNC_STAGES + 2 clk of cs rising.
REQ-033 Readback (macro defined): write reg2 = 0x01, then send 0x82. Result: tx_data = 0x01 with a one-clk tx_valid pulse, colon = 01.
REQ-034 Simultaneous events: the last data byte and cs rise land in the same clk. Result: the byte is written and the state is IDLE afterwards.
REQ-035 Reset mid-write: after command 0x00, assert reset, release, then send 0x55 with cs still low. Result: no write; reg0 = 0x00.
REQ-036 Macro undefined: send 0x81 then 0x99. Result: reg1 stays 0x43, tx_valid = 0, tx_data = 0x00.
